// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial add/subtract unit.
`timescale 1ns/1ps
package serial_arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Ceiling log2; returns 0 for values <= 1, so callers clamp the width to 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// Combinational R-bit digit adder; also exposes the carry into its MSB for overflow detection.
`timescale 1ns/1ps
module digit_adder #(
    parameter int R = 1
) (
    input  logic [R-1:0] x,
    input  logic [R-1:0] y,
    input  logic         cin,
    output logic [R-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    logic [R:0] total;

    always_comb begin
        total    = {1'b0, x} + {1'b0, y} + {{R{1'b0}}, cin};
        s        = total[R-1:0];
        cout     = total[R];
        // The MSB sum bit is x^y^carry_in, so the carry in is recovered from it.
        c_msb_in = x[R-1] ^ y[R-1] ^ total[R-1];
    end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial N-bit add/subtract, R bits per clock, LSB first, start/busy/done handshake.
// Optional macro SERIAL_ADDSUB_SAT_EN: saturate sum on signed overflow.
`timescale 1ns/1ps
module serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int N = 4,
    parameter int R = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int STEPS = N / R;
    localparam int CNT_W = (clog2(STEPS) < 1) ? 1 : clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    generate
        if (R < 1 || N < 2 || R > N || (N % R) != 0) begin : g_bad_params
            $error("serial_addsub: need N >= 2, 1 <= R <= N and N %% R == 0");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [R-1:0] dig_s;
    logic         dig_cout;
    logic         dig_c_msb_in;

    digit_adder #(.R(R)) u_digit_adder (
        .x        (a_q[R-1:0]),
        .y        (b_q[R-1:0]),
        .cin      (carry_q),
        .s        (dig_s),
        .cout     (dig_cout),
        .c_msb_in (dig_c_msb_in)
    );

    always_comb begin
        // NOTE: every signal gets a default here, so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = (sub == MODE_ADD) ? b : ~b;
                    carry_d = (sub == MODE_SUB);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> R;
                b_d     = b_q >> R;
                carry_d = dig_cout;
                cnt_d   = cnt_q + 1'b1;
                sum_d   = (sum_q >> R) | (N'(dig_s) << (N - R));
                if (cnt_q == LAST_STEP) begin
                    cout_d  = dig_cout;
                    ovf_d   = dig_c_msb_in ^ dig_cout;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef SERIAL_ADDSUB_SAT_EN
                    // a_q[R-1] is now the original MSB of A, which picks the saturation direction.
                    if (ovf_d) begin
                        sum_d = a_q[R-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: an R=1 and an R=2 instance, both N=4, checked against an integer model.
`timescale 1ns/1ps
module tb_serial_addsub;

    localparam int N      = 4;
    localparam int STEPS0 = 4;
    localparam int STEPS1 = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start0 = 1'b0, start1 = 1'b0, sub = 1'b0;
    logic [N-1:0] a = '0, b = '0;
    logic         busy0, done0, cout0, ovf0;
    logic         busy1, done1, cout1, ovf1;
    logic [N-1:0] sum0, sum1;

    always #5 clk = ~clk;

    serial_addsub #(.N(N), .R(1)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .sub(sub), .a(a), .b(b),
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0)
    );

    serial_addsub #(.N(N), .R(2)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .sub(sub), .a(a), .b(b),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
        int           done_cyc;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on the operands.
    function automatic exp_t model(input logic [N-1:0] aa, input logic [N-1:0] bb,
                                   input logic s, input int done_cyc);
        exp_t e;
        int sa, sb, ua, ub, res;
        sa  = int'($signed(aa));
        sb  = int'($signed(bb));
        ua  = int'(aa);
        ub  = int'(bb);
        res = s ? sa - sb : sa + sb;
        e.cout     = s ? (ua >= ub) : (ua + ub >= (1 << N));
        e.ovf      = (res > (1 << (N-1)) - 1) || (res < -(1 << (N-1)));
        e.sum      = N'(res);
`ifdef SERIAL_ADDSUB_SAT_EN
        if (e.ovf) e.sum = (res > 0) ? N'((1 << (N-1)) - 1) : N'(1 << (N-1));
`endif
        e.done_cyc = done_cyc;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done0 === 1'b1) begin
            if (exp_q0.size() == 0) begin
                check("r1 spurious done", done0, 1'b0);
            end else begin
                e = exp_q0.pop_front();
                check("r1 sum", sum0, e.sum);
                check("r1 cout", cout0, e.cout);
                check("r1 ovf", ovf0, e.ovf);
                check("r1 done cycle", cyc, e.done_cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done1 === 1'b1) begin
            if (exp_q1.size() == 0) begin
                check("r2 spurious done", done1, 1'b0);
            end else begin
                e = exp_q1.pop_front();
                check("r2 sum", sum1, e.sum);
                check("r2 cout", cout1, e.cout);
                check("r2 ovf", ovf1, e.ovf);
                check("r2 done cycle", cyc, e.done_cyc);
            end
        end
    end

    function automatic int q_size(input int w);
        return (w == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // Called at a negedge: the start is sampled at the next posedge (edge cyc+1).
    task automatic issue(input int w, input logic [N-1:0] aa, input logic [N-1:0] bb, input logic s);
        a   = aa;
        b   = bb;
        sub = s;
        if (w == 0) begin
            start0 = 1'b1;
            exp_q0.push_back(model(aa, bb, s, cyc + 1 + STEPS0));
        end else begin
            start1 = 1'b1;
            exp_q1.push_back(model(aa, bb, s, cyc + 1 + STEPS1));
        end
    endtask

    task automatic drop_start(input int w);
        if (w == 0) start0 = 1'b0;
        else start1 = 1'b0;
    endtask

    task automatic wait_idle(input int w);
        int k;
        k = 0;
        while (q_size(w) != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (q_size(w) != 0) begin
            check(w == 0 ? "r1 done timeout" : "r2 done timeout", q_size(w), 0);
            if (w == 0) exp_q0.delete();
            else exp_q1.delete();
        end
    endtask

    task automatic wait_done(input int w);
        int k;
        k = 0;
        while (((w == 0) ? done0 : done1) !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(w == 0 ? "r1 wait done" : "r2 wait done", (w == 0) ? done0 : done1, 1'b1);
    endtask

    task automatic run_op(input int w, input logic [N-1:0] aa, input logic [N-1:0] bb, input logic s);
        issue(w, aa, bb, s);
        @(negedge clk);
        drop_start(w);
        wait_idle(w);
    endtask

    initial begin
        // Reset state of both instances.
        repeat (3) @(negedge clk);
        check("rst busy", {busy1, busy0}, 2'b00);
        check("rst done", {done1, done0}, 2'b00);
        check("rst sum", {sum1, sum0}, '0);
        check("rst cout/ovf", {cout1, ovf1, cout0, ovf0}, 4'b0000);
        reset = 1'b1;
        @(negedge clk);

        // 1111 + 0111 with busy held for exactly STEPS cycles.
        issue(0, 4'b1111, 4'b0111, 1'b0);
        for (int i = 0; i < STEPS0; i++) begin
            @(negedge clk);
            if (i == 0) drop_start(0);
            check("r1 busy during run", busy0, 1'b1);
        end
        @(negedge clk);
        check("r1 busy after run", busy0, 1'b0);
        wait_idle(0);

        run_op(0, 4'b1110, 4'b0111, 1'b1);
        run_op(0, 4'b0010, 4'b1001, 1'b0);
        run_op(1, 4'b0010, 4'b1001, 1'b0);
        run_op(0, 4'b0111, 4'b0001, 1'b0);

        // Mid-run reset at edge E0+2 aborts with no done pulse.
        run_op(0, 4'b1111, 4'b1111, 1'b0);
        issue(0, 4'b1111, 4'b0000, 1'b0);
        @(negedge clk);
        drop_start(0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_q0.delete();
        check("abort busy", busy0, 1'b0);
        check("abort sum", sum0, '0);
        check("abort done", done0, 1'b0);
        check("abort cout/ovf", {cout0, ovf0}, 2'b00);
        repeat (6) @(negedge clk);
        run_op(0, 4'b0101, 4'b0011, 1'b1);

        // start held with changing operands during RUN.
        issue(0, 4'b0011, 4'b0100, 1'b0);
        for (int i = 0; i < STEPS0; i++) begin
            @(negedge clk);
            a   = N'($urandom);
            b   = N'($urandom);
            sub = 1'($urandom);
        end
        drop_start(0);
        wait_idle(0);

        // Back-to-back: second start lands in the done cycle.
        for (int w = 0; w < 2; w++) begin
            issue(w, 4'b1000, 4'b0001, 1'b1);
            @(negedge clk);
            drop_start(w);
            wait_done(w);
            issue(w, 4'b0110, 4'b0011, 1'b0);
            @(negedge clk);
            drop_start(w);
            wait_idle(w);
        end

        // Randomized traffic on both widths, sometimes chained back-to-back.
        for (int i = 0; i < 40; i++) begin
            int w;
            w = int'($urandom_range(0, 1));
            issue(w, N'($urandom), N'($urandom), 1'($urandom));
            @(negedge clk);
            drop_start(w);
            if ($urandom_range(0, 1) == 1) begin
                wait_done(w);
                issue(w, N'($urandom), N'($urandom), 1'($urandom));
                @(negedge clk);
                drop_start(w);
            end
            wait_idle(w);
        end

        wait_idle(0);
        wait_idle(1);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
